regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Multi-port integer register file with a counting scoreboard; parametrised successor of the single-issue regfile.
//  Sits between decode/issue and writeback. Supplies NRD source operands with same-cycle writeback bypass.
//  Accepts NWR writebacks per cycle. Tracks up to 2**PEND_W-1 in-flight writes per register (WAW allowed).
//  Adds an issue handshake and a scoreboard flush.
// PARAMETERS
//  NREGS   32  architectural registers; AW = $clog2(NREGS)
//  NRD     2   source read ports per issue
//  NWR     2   writeback ports; higher index has priority on same-address conflict
//  PEND_W  2   pending-counter width; per-register saturation limit CMAX = 2**PEND_W-1
//  ZERO_R0 1   1: register 0 reads 0, is never pending, ignores writes
// PORTS
//  clk_i        in   1           clock
//  rst_i        in   1           synchronous active-high reset
//  iss_valid_i  in   1           issue request
//  iss_rd_en_i  in   1           issued instruction writes a destination
//  iss_rd_i     in   AW          destination register
//  iss_rs_i     in   NRD*AW      source registers
//  iss_ready_o  out  1           all sources ready and rd counter below CMAX
//  rs_ready_o   out  NRD         per-source ready
//  rs_data_o    out  NRD*XLEN    per-source operand
//  wb_valid_i   in   NWR         writeback valid
//  wb_addr_i    in   NWR*AW      writeback register
//  wb_data_i    in   NWR*XLEN    writeback data
//  flush_i      in   1           drop all pending state (pipeline kill)
//  busy_o       out  1           any pending counter nonzero (registered view)
// BEHAVIOUR
//  Reset
//  - All pending counters cnt_q[] <= 0. busy_o = 0 the cycle after reset.
//  - RAM is not reset. iss_ready_o / rs_* are combinational and remain valid under reset.
//  Writeback match
//  - m(a) = number of ports k with wb_valid_i[k] && wb_addr_i[k]==a, excluding a==0 when ZERO_R0.
//  Source ready
//  - rs_ready_o[i] = (ZERO_R0 && rs==0) || cnt_q[rs] <= m(rs).
//  Source data (combinational, same cycle)
//  - 0 if (ZERO_R0 && rs==0).
//  - Otherwise wb_data_i of the highest-index matching port.
//  - Otherwise ram[rs].
//  Issue
//  - iss_ready_o = &rs_ready_o && (!iss_rd_en_i || rd==0&&ZERO_R0 || cnt_q[rd]-m(rd) < CMAX).
//  - Fire = iss_valid_i && iss_ready_o && !flush_i.
//  - rd need not be idle: WAW issue is allowed until saturation.
//  Counter update per register a
//  - cnt_d = cnt_q - m(a) + (fire && iss_rd_en_i && iss_rd_i==a).
//  - Subtraction saturates at 0, for stray writebacks after a flush.
//  - Applied on the next clock; issue and writeback to the same a in one cycle net out.
//  Flush
//  - flush_i: cnt_q[] <= 0 next cycle. Issue is suppressed that cycle.
//  - Writebacks that cycle and later still update the RAM.
//  RAM write
//  - At clock edge, each valid port writes. Same address on multiple ports: highest index wins.
//  - a==0 is ignored when ZERO_R0.
//  busy_o
//  - Registered |(cnt_q != 0), updated from cnt_d.
//  - Reflects flush one cycle later.
//  Latency
//  - Written data is visible combinationally the same cycle (bypass) and from RAM the next cycle.
//  - A dependent source becomes ready in the cycle its last pending writeback arrives.
// STRUCTURE
//  - rei_pkg: XLEN (existing); add typedef logic [XLEN-1:0] xlen_t. AW is derived locally from NREGS.
//  - Sub-module regfile_pend_cnt: one per register, saturating up/down counter.
//    Inputs: inc, dec_cnt[$clog2(NWR+1)], clr. Outputs: cnt, nz.
//  - Top: match/popcount logic, bypass muxes, RAM array, and the issue/ready reduction.
// TESTING
//  1 Reset, then issue rs={3,4}, rd=5 -> iss_ready_o=1, rs_data=RAM, cnt[5]=1, busy_o=1 next cycle.
//  2 cnt[5]=1, issue rs0=5 while wb0 writes x5=0xDEAD -> rs_ready_o[0]=1 and rs_data_o[0]=0xDEAD same cycle.
//  3 Issue rd=7 three times (PEND_W=2) -> 4th issue with rd=7 gets iss_ready_o=0.
//    wb x7 once -> 4th issue accepted that cycle.
//  4 wb0 and wb1 both write x9 (0x11, 0x22) -> next-cycle read x9 = 0x22.
//    If cnt[9]=2, it goes to 0.
//  5 cnt[6]=2, flush_i with iss_valid_i=1 -> no fire, cnt[6]=0 and busy_o=0 after one cycle.
//    Later wb x6=0x5 -> RAM updated, cnt stays 0.
//  6 Write x0=0xFF, issue rd=0 and rs=0 -> rs_data_o=0, rs_ready_o=1, busy_o stays 0.

Source files
------------

// File: rtl/rei_pkg.sv
// Shared integer-datapath definitions for the register file and its neighbours.
package rei_pkg;
  localparam int unsigned XLEN = 32;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/regfile_pend_cnt.sv
// Per-register pending-write counter: saturating up/down with synchronous clear.
module regfile_pend_cnt #(
  parameter int unsigned PEND_W = 2,
  parameter int unsigned DW     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic [DW-1:0]     dec_cnt_i,
  input  logic              clr_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              nz_o
);
  localparam int unsigned CW   = ((PEND_W > DW) ? PEND_W : DW) + 1;
  localparam int unsigned CMAX = (1 << PEND_W) - 1;

  logic [PEND_W-1:0] r_cnt;
  logic              r_nz;
  logic [CW-1:0]     w_sub;
  logic [CW-1:0]     w_sum;
  logic [CW-1:0]     w_nxt;

  // Decrement floors at zero so stray writebacks after a flush are harmless.
  always_comb begin
    w_sub = '0;
    if (CW'(r_cnt) > CW'(dec_cnt_i)) begin
      w_sub = CW'(r_cnt) - CW'(dec_cnt_i);
    end
    w_sum = w_sub + CW'(inc_i);
    w_nxt = (w_sum > CW'(CMAX)) ? CW'(CMAX) : w_sum;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
      r_nz  <= 1'b0;
    end else begin
      r_cnt <= PEND_W'(w_nxt);
      r_nz  <= (w_nxt != '0);
    end
  end

  assign cnt_o = r_cnt;
  assign nz_o  = r_nz;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with writeback bypass and a counting scoreboard
// that allows multiple in-flight writes per destination register.
module regfile_mp
  import rei_pkg::*;
#(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 2,
  parameter int unsigned PEND_W  = 2,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        iss_valid_i,
  input  logic                        iss_rd_en_i,
  input  logic [$clog2(NREGS)-1:0]    iss_rd_i,
  input  logic [NRD*$clog2(NREGS)-1:0] iss_rs_i,
  output logic                        iss_ready_o,
  output logic [NRD-1:0]              rs_ready_o,
  output logic [NRD*XLEN-1:0]         rs_data_o,
  input  logic [NWR-1:0]              wb_valid_i,
  input  logic [NWR*$clog2(NREGS)-1:0] wb_addr_i,
  input  logic [NWR*XLEN-1:0]         wb_data_i,
  input  logic                        flush_i,
  output logic                        busy_o
);
  localparam int unsigned AW   = $clog2(NREGS);
  localparam int unsigned MW   = $clog2(NWR + 1);
  localparam int unsigned CW   = ((PEND_W > MW) ? PEND_W : MW) + 1;
  localparam int unsigned CMAX = (1 << PEND_W) - 1;

  xlen_t             r_ram [NREGS];
  logic [MW-1:0]     w_m   [NREGS];
  logic [PEND_W-1:0] w_cnt [NREGS];
  logic [AW-1:0]     w_rs  [NRD];
  logic [NREGS-1:0]  w_inc;
  logic [NREGS-1:0]  w_nz;
  logic              w_rd_ok;
  logic              w_fire;

  // Number of writeback ports hitting each register this cycle.
  always_comb begin
    for (int a = 0; a < NREGS; a++) begin
      w_m[a] = '0;
      for (int k = 0; k < NWR; k++) begin
        if (wb_valid_i[k] && (wb_addr_i[k*AW +: AW] == AW'(a)) && !(ZERO_R0 && (a == 0))) begin
          w_m[a] = w_m[a] + MW'(1);
        end
      end
    end
  end

  // Source readiness and operand bypass; the highest matching port wins.
  always_comb begin
    rs_ready_o = '0;
    rs_data_o  = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rs[i] = iss_rs_i[i*AW +: AW];
      if (ZERO_R0 && (w_rs[i] == '0)) begin
        rs_ready_o[i] = 1'b1;
      end else begin
        rs_ready_o[i] = (CW'(w_cnt[w_rs[i]]) <= CW'(w_m[w_rs[i]]));
        rs_data_o[i*XLEN +: XLEN] = r_ram[w_rs[i]];
        for (int k = 0; k < NWR; k++) begin
          if (wb_valid_i[k] && (wb_addr_i[k*AW +: AW] == w_rs[i])) begin
            rs_data_o[i*XLEN +: XLEN] = wb_data_i[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Destination may already be pending; it only blocks once its counter would saturate.
  always_comb begin
    w_rd_ok = !iss_rd_en_i || (ZERO_R0 && (iss_rd_i == '0)) ||
              (CW'(w_cnt[iss_rd_i]) < (CW'(CMAX) + CW'(w_m[iss_rd_i])));
    iss_ready_o = (&rs_ready_o) && w_rd_ok;
    w_fire      = iss_valid_i && iss_ready_o && !flush_i;
    for (int a = 0; a < NREGS; a++) begin
      w_inc[a] = w_fire && iss_rd_en_i && (iss_rd_i == AW'(a)) && !(ZERO_R0 && (a == 0));
    end
  end

  // Later ports are applied last so the highest index wins an address clash.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NWR; k++) begin
      if (wb_valid_i[k] && !(ZERO_R0 && (wb_addr_i[k*AW +: AW] == '0))) begin
        r_ram[wb_addr_i[k*AW +: AW]] <= wb_data_i[k*XLEN +: XLEN];
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cnt
    regfile_pend_cnt #(
      .PEND_W (PEND_W),
      .DW     (MW)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (w_inc[g]),
      .dec_cnt_i (w_m[g]),
      .clr_i     (flush_i),
      .cnt_o     (w_cnt[g]),
      .nz_o      (w_nz[g])
    );
  end

  assign busy_o = |w_nz;
endmodule

// File: tb/tb_regfile_mp.sv
// Scenario bench for regfile_mp: expectations are queued as stimulus is driven
// and retired against the DUT outputs once they settle.
module tb_regfile_mp;
  import rei_pkg::*;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        iss_valid_i;
  logic        iss_rd_en_i;
  logic [4:0]  iss_rd_i;
  logic [9:0]  iss_rs_i;
  logic        iss_ready_o;
  logic [1:0]  rs_ready_o;
  logic [63:0] rs_data_o;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_addr_i;
  logic [63:0] wb_data_i;
  logic        flush_i;
  logic        busy_o;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] mem [32];
  logic [31:0] got;
  int          n_vec = 0;
  int          n_err = 0;

  regfile_mp dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_en_i (iss_rd_en_i),
    .iss_rd_i    (iss_rd_i),
    .iss_rs_i    (iss_rs_i),
    .iss_ready_o (iss_ready_o),
    .rs_ready_o  (rs_ready_o),
    .rs_data_o   (rs_data_o),
    .wb_valid_i  (wb_valid_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    iss_valid_i = 1'b0; iss_rd_en_i = 1'b0; iss_rd_i = '0; iss_rs_i = '0;
    wb_valid_i = '0; wb_addr_i = '0; wb_data_i = '0; flush_i = 1'b0;
  endtask

  task automatic set_iss(input logic v, input logic en, input logic [4:0] rd,
                         input logic [4:0] rs0, input logic [4:0] rs1);
    iss_valid_i = v; iss_rd_en_i = en; iss_rd_i = rd; iss_rs_i = {rs1, rs0};
  endtask

  task automatic set_wb(input int k, input logic [4:0] a, input logic [31:0] d);
    wb_valid_i[k] = 1'b1; wb_addr_i[k*5 +: 5] = a; wb_data_i[k*32 +: 32] = d;
  endtask

  // Commits pending writebacks to the reference memory, then advances one edge.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (wb_valid_i[k] && wb_addr_i[k*5 +: 5] != 5'd0) mem[wb_addr_i[k*5 +: 5]] = wb_data_i[k*32 +: 32];
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    idle(); rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0; #1;
    sb.push_back('{"reset_busy", 32'd0});
    sb.push_back('{"reset_rs_ready", 32'd3});
    sb.push_back('{"reset_iss_ready", 32'd1});
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(rs_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(iss_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
  endtask

  task automatic test_preload();
    for (int i = 1; i < 16; i += 2) begin
      idle();
      set_wb(0, 5'(i), 32'h100 + 32'(i) * 32'h11);
      set_wb(1, 5'(i + 1), 32'h200 + 32'(i) * 32'h13);
      tick();
    end
    idle(); #1;
    sb.push_back('{"preload_busy", 32'd0});
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
  endtask

  task automatic test_issue();
    idle(); set_iss(1'b1, 1'b1, 5'd5, 5'd3, 5'd4); #1;
    sb.push_back('{"issue_ready", 32'd1});
    sb.push_back('{"issue_rs0_data", mem[3]});
    sb.push_back('{"issue_rs1_data", mem[4]});
    got = 32'(iss_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = rs_data_o[31:0]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = rs_data_o[63:32]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
    idle(); set_iss(1'b1, 1'b0, 5'd0, 5'd5, 5'd0); #1;
    sb.push_back('{"issue_busy", 32'd1});
    sb.push_back('{"issue_rs_pending", 32'd2});
    sb.push_back('{"issue_dep_blocked", 32'd0});
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(rs_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(iss_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
  endtask

  task automatic test_bypass();
    idle(); set_iss(1'b1, 1'b0, 5'd0, 5'd5, 5'd3); set_wb(0, 5'd5, 32'hDEAD); #1;
    sb.push_back('{"bypass_rs_ready", 32'd3});
    sb.push_back('{"bypass_data", 32'hDEAD});
    got = 32'(rs_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = rs_data_o[31:0]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
    idle(); set_iss(1'b0, 1'b0, 5'd0, 5'd5, 5'd0); #1;
    sb.push_back('{"bypass_busy_clear", 32'd0});
    sb.push_back('{"bypass_ram_data", mem[5]});
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = rs_data_o[31:0]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 3; n++) begin
      idle(); set_iss(1'b1, 1'b1, 5'd7, 5'd0, 5'd0); #1;
      sb.push_back('{"sat_fill_ready", 32'd1});
      got = 32'(iss_ready_o); e = sb.pop_front(); n_vec++;
      if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
      tick();
    end
    idle(); set_iss(1'b1, 1'b1, 5'd7, 5'd0, 5'd0); #1;
    sb.push_back('{"sat_full_blocked", 32'd0});
    got = 32'(iss_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
    set_wb(0, 5'd7, 32'h77); #1;
    sb.push_back('{"sat_wb_frees", 32'd1});
    got = 32'(iss_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
    // Counter is back at the limit: two writebacks are not enough to release a reader.
    idle(); set_iss(1'b0, 1'b0, 5'd0, 5'd7, 5'd0); set_wb(0, 5'd7, 32'h71); set_wb(1, 5'd7, 32'h72); #1;
    sb.push_back('{"sat_two_of_three", 32'd2});
    got = 32'(rs_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
    idle(); set_iss(1'b0, 1'b0, 5'd0, 5'd7, 5'd0); set_wb(1, 5'd7, 32'h73); #1;
    sb.push_back('{"sat_last_wb_ready", 32'd3});
    got = 32'(rs_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
    idle(); #1;
    sb.push_back('{"sat_drained_busy", 32'd0});
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
  endtask

  task automatic test_dual_wb();
    for (int n = 0; n < 2; n++) begin
      idle(); set_iss(1'b1, 1'b1, 5'd9, 5'd0, 5'd0); tick();
    end
    idle(); set_iss(1'b0, 1'b0, 5'd0, 5'd9, 5'd0); set_wb(0, 5'd9, 32'h11); set_wb(1, 5'd9, 32'h22); #1;
    sb.push_back('{"dual_ready", 32'd3});
    sb.push_back('{"dual_bypass", 32'h22});
    got = 32'(rs_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = rs_data_o[31:0]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
    idle(); set_iss(1'b0, 1'b0, 5'd0, 5'd9, 5'd0); #1;
    sb.push_back('{"dual_ram", mem[9]});
    sb.push_back('{"dual_busy", 32'd0});
    got = rs_data_o[31:0]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
  endtask

  task automatic test_flush();
    for (int n = 0; n < 2; n++) begin
      idle(); set_iss(1'b1, 1'b1, 5'd6, 5'd0, 5'd0); tick();
    end
    idle(); set_iss(1'b1, 1'b1, 5'd6, 5'd0, 5'd0); flush_i = 1'b1; tick();
    idle(); set_iss(1'b0, 1'b0, 5'd0, 5'd6, 5'd0); #1;
    sb.push_back('{"flush_busy", 32'd0});
    sb.push_back('{"flush_rs_ready", 32'd3});
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(rs_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    set_wb(0, 5'd6, 32'h5); tick();
    idle(); set_iss(1'b0, 1'b0, 5'd0, 5'd6, 5'd0); #1;
    sb.push_back('{"flush_stray_ram", 32'h5});
    sb.push_back('{"flush_stray_busy", 32'd0});
    got = rs_data_o[31:0]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
  endtask

  task automatic test_r0();
    idle(); set_iss(1'b1, 1'b1, 5'd0, 5'd0, 5'd0); set_wb(0, 5'd0, 32'hFF); #1;
    sb.push_back('{"r0_data", 32'd0});
    sb.push_back('{"r0_rs_ready", 32'd3});
    sb.push_back('{"r0_iss_ready", 32'd1});
    got = rs_data_o[31:0]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(rs_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = 32'(iss_ready_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    tick();
    idle(); #1;
    sb.push_back('{"r0_busy", 32'd0});
    sb.push_back('{"r0_ram_read", 32'd0});
    got = 32'(busy_o); e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
    got = rs_data_o[31:0]; e = sb.pop_front(); n_vec++;
    if (got !== e.v) begin n_err++; $display("FAIL %s: got %h, expected %h", e.nm, got, e.v); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    idle(); rst_i = 1'b1;
    test_reset();
    test_preload();
    test_issue();
    test_bypass();
    test_saturate();
    test_dual_wb();
    test_flush();
    test_r0();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
